// File: rtl/data_mem_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the data-memory responder (slave).
// memErr exists only when DMEM_RANGE_CHECK_EN is defined.
interface data_mem_responder_if;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] readData;
  logic        ready;
`ifdef DMEM_RANGE_CHECK_EN
  logic        memErr;
`endif

  modport master (
    output memAdr, writeData, memRead, memWrite,
`ifdef DMEM_RANGE_CHECK_EN
    input  memErr,
`endif
    input  readData, ready
  );

  modport slave (
    input  memAdr, writeData, memRead, memWrite,
`ifdef DMEM_RANGE_CHECK_EN
    output memErr,
`endif
    output readData, ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with fixed wait states; ready low stalls the pipeline.
// Optional address range check with memErr output when DMEM_RANGE_CHECK_EN is defined.
module data_mem_responder #(
  parameter int ADDR_BASE   = 1024,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] BASE     = 32'(ADDR_BASE);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [31:0] LIMIT    = 32'(ADDR_BASE + 4 * DEPTH);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     adr_q, wdata_q;
  logic            wr_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            commit;
  logic [31:0]     acc_adr, acc_wd;
  logic            acc_wr;
  logic            acc_ok;
  logic [IDX_W-1:0] idx;

  assign req = bus.memRead | bus.memWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (WAIT_STATES > 0) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = DONE;
        end
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = ((state_q == IDLE) && !req) || (state_q == DONE);
  end

  // With zero wait states the access commits on the accepting edge, so use the live inputs then.
  assign commit  = (state_d == DONE);
  assign acc_adr = (state_q == IDLE) ? bus.memAdr    : adr_q;
  assign acc_wd  = (state_q == IDLE) ? bus.writeData : wdata_q;
  assign acc_wr  = (state_q == IDLE) ? bus.memWrite  : wr_q;
  assign idx     = IDX_W'((acc_adr - BASE) >> 2);

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_ok = (acc_adr >= BASE) && (acc_adr < LIMIT) && (acc_adr[1:0] == 2'b00);
`else
  assign acc_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if ((state_q == IDLE) && req) begin
        adr_q   <= bus.memAdr;
        wdata_q <= bus.writeData;
        wr_q    <= bus.memWrite;
      end
      if (commit && !acc_wr) rdata_q <= acc_ok ? mem[idx] : '0;
    end
  end

  // RAM contents survive reset; a store still pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc_wr && acc_ok) mem[idx] <= acc_wd;
  end

  assign bus.readData = rdata_q;

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= commit && !acc_ok;
  end
  assign bus.memErr = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table vectors, reset corner case, random ops vs model.
module tb_data_mem_responder;
  localparam int WS    = 4;
  localparam int BASE  = 1024;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_m;

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a >= 32'(BASE)) && (a < 32'(BASE + 4 * DEPTH)) && (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  // Memory seen as a plain word array indexed modulo DEPTH.
  function automatic void model_op(input bit rd, input bit wr, input logic [31:0] a,
                                   input logic [31:0] wd, output logic [31:0] exp_rd,
                                   output bit exp_err);
    logic [31:0] w;
    int idx;
    w       = (a - 32'(BASE)) >> 2;
    idx     = int'(w % 32'(DEPTH));
    exp_err = !addr_ok(a);
    if (wr) begin
      if (!exp_err) mem_m[idx] = wd;
    end else if (rd) begin
      rd_m = exp_err ? 32'h0 : mem_m[idx];
    end
    exp_rd = rd_m;
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output int lows, output logic [31:0] rdv, output logic err);
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.memAdr    = a;
    bus.writeData = wd;
    lows = 0;
    err  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready === 1'b1) break;
      lows++;
      if (lows > 40) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout actual=low_for_%0d_cycles required=high", lows);
        break;
      end
    end
    rdv = bus.readData;
`ifdef DMEM_RANGE_CHECK_EN
    err = bus.memErr;
`endif
    @(posedge clk);
    #1;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
  endtask

  task automatic run_op(input string name, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_tbl, input logic [31:0] t_rd,
                        input bit t_err);
    logic [31:0] m_rd, rdv;
    bit          m_err;
    int          lows;
    logic        err;
    model_op(rd, wr, a, wd, m_rd, m_err);
    if (use_tbl) begin
      m_rd  = t_rd;
      m_err = t_err;
    end
    access(rd, wr, a, wd, lows, rdv, err);
    check32({name, "_lowcycles"}, 32'(lows), 32'(WS + 1));
    check32({name, "_readData"}, rdv, m_rd);
`ifdef DMEM_RANGE_CHECK_EN
    check32({name, "_memErr"}, {31'b0, err}, {31'b0, m_err});
`endif
    #1;
    check32({name, "_ready_idle"}, {31'b0, bus.ready}, 32'd1);
`ifdef DMEM_RANGE_CHECK_EN
    check32({name, "_memErr_idle"}, {31'b0, bus.memErr}, 32'd0);
`endif
  endtask

  initial begin
    bit mc;
`ifdef DMEM_RANGE_CHECK_EN
    mc = 1'b1;
`else
    mc = 1'b0;
`endif
    tbl[0] = '{"st1028",   0, 1, 32'd1028, 32'h12345678, 32'hC0DE0000, 0};
    tbl[1] = '{"ld1028",   1, 0, 32'd1028, 32'h0,        32'h12345678, 0};
    tbl[2] = '{"st1032",   0, 1, 32'd1032, 32'hCAFEF00D, 32'h12345678, 0};
    tbl[3] = '{"ld1032",   1, 0, 32'd1032, 32'h0,        32'hCAFEF00D, 0};
    tbl[4] = '{"ld1036",   1, 0, 32'd1036, 32'h0,        32'hC0DE0003, 0};
    tbl[5] = '{"both1036", 1, 1, 32'd1036, 32'hA5A5A5A5, 32'hC0DE0003, 0};
    tbl[6] = '{"ld1036b",  1, 0, 32'd1036, 32'h0,        32'hA5A5A5A5, 0};
    tbl[7] = '{"stwrap",   0, 1, 32'd1280, 32'h00000001, 32'hA5A5A5A5, mc};
    tbl[8] = '{"ld1024w",  1, 0, 32'd1024, 32'h0,        mc ? 32'hC0DE0000 : 32'h1, 0};
    tbl[9] = '{"ld1026",   1, 0, 32'd1026, 32'h0,        mc ? 32'h0 : 32'h1, mc};

    rd_m = 32'h0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'hx;
    rst           = 1'b1;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.memAdr    = 32'h0;
    bus.writeData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check32("reset_ready", {31'b0, bus.ready}, 32'd1);
    check32("reset_readData", bus.readData, 32'h0);
`ifdef DMEM_RANGE_CHECK_EN
    check32("reset_memErr", {31'b0, bus.memErr}, 32'd0);
`endif

    // Give every word a known value first.
    for (int i = 0; i < DEPTH; i++)
      run_op($sformatf("pre%0d", i), 1'b0, 1'b1, 32'(BASE + 4 * i), 32'hC0DE0000 | 32'(i),
             1'b0, 32'h0, 1'b0);

    // Reset in the 2nd BUSY cycle of a store drops the store and clears readData.
    if (WS >= 2) begin
      bus.memWrite  = 1'b1;
      bus.memAdr    = 32'd1024;
      bus.writeData = 32'hDEADBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check32("midbusy_ready", {31'b0, bus.ready}, 32'd0);
      rst          = 1'b1;
      bus.memWrite = 1'b0;
      @(posedge clk); #1;
      rst  = 1'b0;
      rd_m = 32'h0;
      #1;
      check32("midbusy_rst_ready", {31'b0, bus.ready}, 32'd1);
      check32("midbusy_rst_readData", bus.readData, 32'h0);
    end
    run_op("ld1024_after_rst", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 32'hC0DE0000, 1'b0);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd, 1'b1,
             tbl[i].exp_rd, tbl[i].exp_err);

    for (int i = 0; i < 60; i++) begin
      bit          r, w;
      logic [31:0] a;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(900, 1400));
      else                           a = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
      run_op($sformatf("rnd%0d", i), r, w, a, $urandom, 1'b0, 32'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
